// File: rtl/sobel_pkg.sv
// sobel_pkg: mode encodings, kernel coefficients and FSM states
// shared by the streaming 3x3 Sobel window filter.
package sobel_pkg;

   typedef enum logic [1:0] {
      MODE_GX  = 2'b00,
      MODE_GY  = 2'b01,
      MODE_MAG = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      FILL,
      RUN,
      DRAIN
   } state_e;

   // Indexed [row][col], row 0 = top, col 0 = left.
   localparam int KX [3][3] = '{
      '{1, 0, -1},
      '{2, 0, -2},
      '{1, 0, -1}
   };

   localparam int KY [3][3] = '{
      '{ 1,  2,  1},
      '{ 0,  0,  0},
      '{-1, -2, -1}
   };

endpackage

// File: rtl/sobel_window_filter_if.sv
// sobel_window_filter_if: pixel stream in, filtered result stream out,
// plus end-of-frame pulse.
interface sobel_window_filter_if #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 180,
   parameter int IMG_H = 180
);
   localparam int OUT_W = PIX_W + 3;

   logic                     in_valid;
   logic [PIX_W-1:0]         in_pix;
   logic [1:0]               mode;
   logic                     out_valid;
   logic [OUT_W-1:0]         out_pix;
   logic [$clog2(IMG_H)-1:0] out_row;
   logic [$clog2(IMG_W)-1:0] out_col;
   logic                     done;

   modport master (
      output in_valid, in_pix, mode,
      input  out_valid, out_pix, out_row, out_col, done
   );

   modport slave (
      input  in_valid, in_pix, mode,
      output out_valid, out_pix, out_row, out_col, done
   );

endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: enable-gated shift line of DEPTH samples;
// dout is the sample written DEPTH accepted cycles ago.
module sobel_line_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 180
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sobel_window_filter.sv
// sobel_window_filter: raster-order 3x3 Sobel filter emitting Gx, Gy
// or |Gx|+|Gy| for every interior pixel, two cycles after acceptance.
module sobel_window_filter
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int IMG_W = 180,
   parameter int IMG_H = 180
) (
   input logic               clk,
   input logic               rst,
   sobel_window_filter_if.slave bus
);

   localparam int OUT_W = PIX_W + 3;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   logic                    acc;
   logic [PIX_W-1:0]        up1;
   logic [PIX_W-1:0]        up2;
   logic [PIX_W-1:0]        colv [3];
   logic [PIX_W-1:0]        win  [3][3];

   logic [CW-1:0]           col;
   logic [RW-1:0]           row;
   logic                    col_last;
   logic                    row_last;
   logic [1:0]              mode_q;

   state_e                  state;
   state_e                  state_nx;
   logic                    emit;
   logic                    done_d;

   logic                    s1_v;
   logic [RW-1:0]           s1_row;
   logic [CW-1:0]           s1_col;

   logic signed [OUT_W-1:0] gx;
   logic signed [OUT_W-1:0] gy;
   logic signed [OUT_W-1:0] ax;
   logic signed [OUT_W-1:0] ay;
   logic [OUT_W-1:0]        res;

   logic                    ov_q;
   logic                    done_q;
   logic [OUT_W-1:0]        pix_q;
   logic [RW-1:0]           row_q;
   logic [CW-1:0]           col_q;

   assign acc      = bus.in_valid;
   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (acc) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Mode is frozen for the whole frame at its first pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_GX;
      end else if (acc && col == '0 && row == '0) begin
         mode_q <= bus.mode;
      end
   end

   sobel_line_buffer #(
      .WIDTH (PIX_W),
      .DEPTH (IMG_W)
   ) u_lb0 (
      .clk  (clk),
      .en   (acc),
      .din  (bus.in_pix),
      .dout (up1)
   );

   sobel_line_buffer #(
      .WIDTH (PIX_W),
      .DEPTH (IMG_W)
   ) u_lb1 (
      .clk  (clk),
      .en   (acc),
      .din  (up1),
      .dout (up2)
   );

   assign colv[0] = up2;
   assign colv[1] = up1;
   assign colv[2] = bus.in_pix;

   always_ff @(posedge clk) begin
      if (acc) begin
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
            win[i][2] <= colv[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      emit     = 1'b0;
      done_d   = 1'b0;
      unique case (state)
         FILL: begin
            if (acc && row == RW'(2) && col == CW'(1)) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            emit = acc && (col >= CW'(2));
            if (acc && row_last && col_last) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            done_d   = 1'b1;
            state_nx = FILL;
         end
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_row <= '0;
         s1_col <= '0;
      end else begin
         s1_v <= emit;
         if (emit) begin
            s1_row <= row - 1'b1;
            s1_col <= col - 1'b1;
         end
      end
   end

   always_comb begin
      gx = '0;
      gy = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            gx = gx + OUT_W'(KX[i][j]) * $signed(OUT_W'(win[i][j]));
            gy = gy + OUT_W'(KY[i][j]) * $signed(OUT_W'(win[i][j]));
         end
      end
      ax = gx[OUT_W-1] ? -gx : gx;
      ay = gy[OUT_W-1] ? -gy : gy;
   end

   always_comb begin
      res = '0;
      unique case (1'b1)
         (mode_q == MODE_GX): res = gx;
         (mode_q == MODE_GY): res = gy;
         default:             res = ax + ay;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q   <= 1'b0;
         done_q <= 1'b0;
         pix_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         ov_q   <= s1_v;
         done_q <= done_d;
         if (s1_v) begin
            pix_q <= res;
            row_q <= s1_row;
            col_q <= s1_col;
         end
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.done      = done_q;
   assign bus.out_pix   = pix_q;
   assign bus.out_row   = row_q;
   assign bus.out_col   = col_q;

endmodule

// File: doc/sobel_window_filter.md
# sobel_window_filter

Streaming 3×3 Sobel edge filter for the finger-vein preprocessing path, replacing the fixed 9-bit, three-tap single-row pixel buffer. It accepts one pixel per valid cycle in raster order and keeps two line buffers of depth IMG_W. It forms the full 3×3 window and emits Gx, Gy or |Gx|+|Gy| for every interior pixel. A one-cycle done pulse goes to the control FSM at end of frame.

## Interface
- PIX_W, 8: input pixel width (unsigned).
- IMG_W, 180: pixels per row; minimum 3.
- IMG_H, 180: rows per frame; minimum 3.
- OUT_W, PIX_W+3: result width (derived, not overridable).
- Reset: one clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_pix is valid this cycle; no backpressure.
- in_pix  in  PIX_W  pixel, raster order (row-major, top-left first).
- mode  in  2  00 Gx, 01 Gy, 10/11 magnitude; sampled at frame start.
- out_valid  out  1  out_pix valid this cycle.
- out_pix  out  OUT_W  result; two's complement for Gx/Gy, unsigned for magnitude.
- out_row  out  $clog2(IMG_H)  row of the window centre for out_pix.
- out_col  out  $clog2(IMG_W)  column of the window centre for out_pix.
- done  out  1  single-cycle pulse with the frame's last out_valid.

## Operation
- Counters
  - col and row count accepted pixels only. in_valid=0 cycles freeze all state except the output pipeline drain.
  - col wraps IMG_W-1→0 and increments row.
  - row wraps IMG_H-1→0, so the next frame follows with no idle cycle.
- Line buffers: two cascaded, each depth IMG_W, written only on in_valid. Window columns shift on every accepted pixel.
- Kernels:
  - Gx = [1 0 -1; 2 0 -2; 1 0 -1], left minus right.
  - Gy = [1 2 1; 0 0 0; -1 -2 -1], top minus bottom.
- Arithmetic:
  - Gx and Gy are computed in OUT_W-bit signed; the range is ±4·(2^PIX_W−1), so there is no overflow.
  - Magnitude = |Gx|+|Gy|, at most 8·(2^PIX_W−1), and fits OUT_W unsigned. No saturation.
- Output set:
  - Only interior centres are emitted: rows 1..IMG_H-2, cols 1..IMG_W-2.
  - Exactly (IMG_W-2)·(IMG_H-2) outputs per frame.
  - Window contents never straddle a row wrap.
- Mode: latched when pixel (0,0) is accepted. Changes mid-frame take effect on the next frame.
- FSM:
  - FILL: rows 0-1 plus the first 2 pixels of row 2. No emissions.
  - RUN: an emission is scheduled for each accepted pixel with col≥2 and row≥2.
  - DRAIN: after pixel (IMG_H-1, IMG_W-1), until the last result leaves the pipeline. done is asserted on that cycle.
  - Returns to FILL.

## Timing
- Reset values: out_valid=0, done=0, out_pix=0, out_row=0, out_col=0. Counters, state (FILL) and latched mode (00) are cleared. Line-buffer contents don't care.
- Latency:
  - The result for centre (r,c) appears with out_valid exactly 2 clk after the in_valid cycle that accepted pixel (r+1,c+1).
  - Stage 1 registers the window; stage 2 registers the sum/abs.
  - Latency is independent of later in_valid gaps.
- Throughput: one result per accepted pixel in RUN; continuous input gives continuous out_valid within a row. There is a 2-cycle out_valid gap at each row boundary.
- done is asserted in the same cycle as the final out_valid, (r,c)=(IMG_H-2, IMG_W-2).
- Next-frame pixels accepted during DRAIN are legal. They enter FILL without corrupting the draining results.
- Reset mid-frame: out_valid and done are 0 from the cycle after rst is sampled high. In-flight results are discarded. The next accepted pixel is (0,0).

## Structure
- Shared package sobel_pkg holds:
  - the mode encodings (MODE_GX, MODE_GY, MODE_MAG);
  - the Gx and Gy coefficient constants;
  - the FSM state enum (FILL, RUN, DRAIN).
- One sub-module, sobel_line_buffer: parametrised by WIDTH and DEPTH, with enable-gated shift and an output of the delayed sample. It is instantiated twice.

## Test plan
- IMG_W=IMG_H=5, PIX_W=8, flat frame of 100s, mode 10 → 9 outputs, all 0, centres (1..3, 1..3) in raster order; done once with the 9th output.
- Same size, cols 0-1 = 0 and cols 2-4 = 255, mode 00 → per row: col1 −1020, col2 −1020, col3 0. Mode 10 → 1020, 1020, 0. Mode 01 → all 0.
- Horizontal step (rows 0-1 = 0, rows 2-4 = 255), mode 01 → row1 −1020, row2 −1020, row3 0. Mode 00 → all 0.
- Random in_valid gaps (≈40% idle) on the vertical-step frame → values and order identical to the gap-free case; each out_valid exactly 2 clk after its (r+1,c+1) acceptance.
- rst pulsed after 12 accepted pixels, then a full flat-100 frame → no out_valid until the new frame's (2,2) acceptance; 9 zeros; one done.
- mode switched 00→10 mid-frame, then back-to-back frames → frame 1 all Gx, frame 2 all magnitude; no gap or loss at the frame seam.
